// File: rtl/pic_program_sequencer_if.sv
// rtl/pic_program_sequencer_if.sv - 8259A CPU-side write bus driven by the programming sequencer
interface pic_program_sequencer_if;
    logic       chip_select_n;
    logic       write_enable_n;
    logic       address;
    logic [7:0] data_bus_out;
    logic       data_bus_out_en;

    modport master (
        output chip_select_n,
        output write_enable_n,
        output address,
        output data_bus_out,
        output data_bus_out_en
    );

    modport slave (
        input chip_select_n,
        input write_enable_n,
        input address,
        input data_bus_out,
        input data_bus_out_en
    );
endinterface

// File: rtl/pic_program_sequencer.sv
// rtl/pic_program_sequencer.sv - issues ICW1..ICW4/OCW1 (plus OCW3 under PIC_SEQ_OCW3_EN) writes to an 8259A
module pic_program_sequencer #(
    parameter int WR_PULSE = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] icw1,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [7:0] icw4,
    input  logic [7:0] ocw1,
    input  logic [7:0] ocw3,
    pic_program_sequencer_if.master bus,
    output logic       busy,
    output logic       done
);
    localparam int WP = (WR_PULSE < 1) ? 1 : WR_PULSE;
    localparam int CW = $clog2(WP + 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, FINISH} state_t;
    typedef enum logic [2:0] {S_ICW1, S_ICW2, S_ICW3, S_ICW4, S_OCW1, S_OCW3} step_t;

    state_t        state, state_next;
    step_t         step, step_next, step_after;
    logic [CW-1:0] cnt, cnt_next;
    logic          load, last_step;
    logic [7:0]    icw1_q, icw2_q, icw3_q, icw4_q, ocw1_q;
    logic          step_a0;
    logic [7:0]    step_data;
    logic          cs_n, we_n, drive;

`ifdef PIC_SEQ_OCW3_EN
    logic [7:0]    ocw3_q;
`else
    logic          unused_ocw3;
    assign unused_ocw3 = ^ocw3;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            step   <= S_ICW1;
            cnt    <= '0;
            icw1_q <= 8'h00;
            icw2_q <= 8'h00;
            icw3_q <= 8'h00;
            icw4_q <= 8'h00;
            ocw1_q <= 8'h00;
`ifdef PIC_SEQ_OCW3_EN
            ocw3_q <= 8'h00;
`endif
        end else begin
            state <= state_next;
            step  <= step_next;
            cnt   <= cnt_next;
            if (load) begin
                icw1_q <= icw1;
                icw2_q <= icw2;
                icw3_q <= icw3;
                icw4_q <= icw4;
                ocw1_q <= ocw1;
`ifdef PIC_SEQ_OCW3_EN
                ocw3_q <= ocw3;
`endif
            end
        end
    end

    // Skip decisions use the latched ICW1: bit1 = SNGL (no ICW3), bit0 = IC4 (ICW4 needed).
    always_comb begin
        step_after = S_OCW1;
        case (step)
            S_ICW1:  step_after = S_ICW2;
            S_ICW2:  step_after = !icw1_q[1] ? S_ICW3 : (icw1_q[0] ? S_ICW4 : S_OCW1);
            S_ICW3:  step_after = icw1_q[0] ? S_ICW4 : S_OCW1;
            S_ICW4:  step_after = S_OCW1;
`ifdef PIC_SEQ_OCW3_EN
            S_OCW1:  step_after = S_OCW3;
`endif
            default: step_after = S_OCW1;
        endcase
    end

`ifdef PIC_SEQ_OCW3_EN
    assign last_step = (step == S_OCW3);
`else
    assign last_step = (step == S_OCW1);
`endif

    always_comb begin
        step_a0   = 1'b1;
        step_data = 8'h00;
        case (step)
            S_ICW1: begin step_a0 = 1'b0; step_data = icw1_q | 8'h10; end
            S_ICW2: step_data = icw2_q;
            S_ICW3: step_data = icw3_q;
            S_ICW4: step_data = icw4_q;
            S_OCW1: step_data = ocw1_q;
`ifdef PIC_SEQ_OCW3_EN
            S_OCW3: begin step_a0 = 1'b0; step_data = (ocw3_q & 8'h67) | 8'h08; end
`endif
            default: step_data = 8'h00;
        endcase
    end

    always_comb begin
        state_next = state;
        step_next  = step;
        cnt_next   = cnt;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SETUP;
                    step_next  = S_ICW1;
                    load       = 1'b1;
                end
            end
            SETUP: begin
                state_next = STROBE;
                cnt_next   = CW'(WP);
            end
            STROBE: begin
                if (cnt == CW'(1)) state_next = HOLD;
                else               cnt_next   = cnt - CW'(1);
            end
            HOLD: begin
                if (last_step) begin
                    state_next = FINISH;
                end else begin
                    state_next = SETUP;
                    step_next  = step_after;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Chip select and data stay asserted from SETUP through HOLD, so back-to-back writes keep CS low.
    assign drive = (state == SETUP) || (state == STROBE) || (state == HOLD);
    assign cs_n  = !drive;
    assign we_n  = (state != STROBE);

    assign bus.chip_select_n   = cs_n;
    assign bus.write_enable_n  = we_n;
    assign bus.address         = drive ? step_a0 : 1'b0;
    assign bus.data_bus_out    = drive ? step_data : 8'h00;
    assign bus.data_bus_out_en = drive;
    assign busy                = drive;
    assign done                = (state == FINISH);
endmodule

// File: tb/tb_pic_program_sequencer.sv
// tb/tb_pic_program_sequencer.sv - directed vector bench for pic_program_sequencer at WR_PULSE 2, 1 and 0
module tb_pic_program_sequencer;
    logic       clock;
    logic       reset;
    logic       start_v [3];
    logic [7:0] icw1, icw2, icw3, icw4, ocw1, ocw3;
    logic       busy_v [3];
    logic       done_v [3];
    logic [13:0] obs_v [3];

    int n_chk;
    int n_fail;

    pic_program_sequencer_if bus0();
    pic_program_sequencer_if bus1();
    pic_program_sequencer_if bus2();

    pic_program_sequencer #(.WR_PULSE(2)) dut0 (
        .clock(clock), .reset(reset), .start(start_v[0]),
        .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4), .ocw1(ocw1), .ocw3(ocw3),
        .bus(bus0.master), .busy(busy_v[0]), .done(done_v[0])
    );
    pic_program_sequencer #(.WR_PULSE(1)) dut1 (
        .clock(clock), .reset(reset), .start(start_v[1]),
        .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4), .ocw1(ocw1), .ocw3(ocw3),
        .bus(bus1.master), .busy(busy_v[1]), .done(done_v[1])
    );
    pic_program_sequencer #(.WR_PULSE(0)) dut2 (
        .clock(clock), .reset(reset), .start(start_v[2]),
        .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4), .ocw1(ocw1), .ocw3(ocw3),
        .bus(bus2.master), .busy(busy_v[2]), .done(done_v[2])
    );

    // {cs_n, we_n, a0, data_en, busy, done, data}
    assign obs_v[0] = {bus0.chip_select_n, bus0.write_enable_n, bus0.address, bus0.data_bus_out_en,
                       busy_v[0], done_v[0], bus0.data_bus_out};
    assign obs_v[1] = {bus1.chip_select_n, bus1.write_enable_n, bus1.address, bus1.data_bus_out_en,
                       busy_v[1], done_v[1], bus1.data_bus_out};
    assign obs_v[2] = {bus2.chip_select_n, bus2.write_enable_n, bus2.address, bus2.data_bus_out_en,
                       busy_v[2], done_v[2], bus2.data_bus_out};

    localparam logic [13:0] IDLE_OBS = 14'b1100_00_0000_0000;
    localparam logic [13:0] DONE_OBS = 14'b1100_01_0000_0000;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int              dut;
        logic [7:0]      i1, i2, i3, i4, o1;
        int              nw;
        logic [5:0][8:0] w;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(input int dut, input logic [7:0] i1, i2, i3, i4, o1, input int nw,
                                input logic [8:0] w0, w1, w2, w3, w4);
        vec_t v;
        v.dut = dut; v.i1 = i1; v.i2 = i2; v.i3 = i3; v.i4 = i4; v.o1 = o1; v.nw = nw;
        v.w = '0;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4;
        return v;
    endfunction

    task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    function automatic logic [13:0] write_obs(input logic we_low, input logic [8:0] w);
        return {1'b0, !we_low, w[8], 1'b1, 1'b1, 1'b0, w[7:0]};
    endfunction

    task automatic run_seq(input vec_t v, input bit hold, input bit mutate);
        int d, p, n;
        logic [8:0] wexp;
        d = v.dut;
        p = (d == 0) ? 2 : 1;
        n = v.nw;
`ifdef PIC_SEQ_OCW3_EN
        n = n + 1;
`endif
        icw1 = v.i1; icw2 = v.i2; icw3 = v.i3; icw4 = v.i4; ocw1 = v.o1;
        @(negedge clock);
        start_v[d] = 1'b1;
        @(posedge clock);
        for (int i = 0; i < n; i++) begin
            wexp = (i < v.nw) ? v.w[i] : 9'h06F;
            for (int c = 0; c < p + 2; c++) begin
                @(negedge clock);
                if (!hold) start_v[d] = 1'b0;
                if (mutate && i == 1 && c == 0) begin
                    icw1 = 8'h55; icw2 = 8'h66; icw3 = 8'h77; icw4 = 8'h88; ocw1 = 8'h99;
                end
                chk($sformatf("dut%0d w%0d c%0d", d, i, c), obs_v[d],
                    write_obs((c >= 1) && (c <= p), wexp));
            end
        end
        @(negedge clock);
        chk($sformatf("dut%0d done", d), obs_v[d], DONE_OBS);
        @(negedge clock);
        chk($sformatf("dut%0d idle", d), obs_v[d], IDLE_OBS);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        reset = 1'b1;
        for (int d = 0; d < 3; d++) start_v[d] = 1'b0;
        icw1 = 8'h00; icw2 = 8'h00; icw3 = 8'h00; icw4 = 8'h00; ocw1 = 8'h00; ocw3 = 8'hFF;

        vecs[0] = mk(0, 8'h02, 8'h20, 8'h00, 8'h01, 8'hFB, 3, 9'h012, 9'h120, 9'h1FB, 9'h000, 9'h000);
        vecs[1] = mk(0, 8'h11, 8'h08, 8'h04, 8'h1D, 8'h00, 5, 9'h011, 9'h108, 9'h104, 9'h11D, 9'h100);
        vecs[2] = mk(0, 8'h13, 8'h70, 8'hAA, 8'h03, 8'h5A, 4, 9'h013, 9'h170, 9'h103, 9'h15A, 9'h000);
        vecs[3] = mk(0, 8'hE0, 8'hC8, 8'h80, 8'h00, 8'hFF, 4, 9'h0F0, 9'h1C8, 9'h180, 9'h1FF, 9'h000);
        vecs[4] = mk(1, 8'h02, 8'h20, 8'h00, 8'h01, 8'hFB, 3, 9'h012, 9'h120, 9'h1FB, 9'h000, 9'h000);
        vecs[5] = mk(2, 8'h11, 8'h08, 8'h04, 8'h1D, 8'h00, 5, 9'h011, 9'h108, 9'h104, 9'h11D, 9'h100);

        repeat (2) @(negedge clock);
        for (int d = 0; d < 3; d++) chk($sformatf("reset dut%0d", d), obs_v[d], IDLE_OBS);
        reset = 1'b0;

        for (int k = 0; k < 6; k++) run_seq(vecs[k], 1'b0, 1'b0);

        // Abort during ICW2 strobe: SETUP/STROBE/HOLD of ICW1 take negedges 0..3, ICW2 STROBE is negedge 5.
        icw1 = 8'h11; icw2 = 8'h08; icw3 = 8'h04; icw4 = 8'h1D; ocw1 = 8'h00;
        @(negedge clock);
        start_v[0] = 1'b1;
        @(posedge clock);
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            start_v[0] = 1'b0;
        end
        chk("abort pre strobe", obs_v[0], write_obs(1'b1, 9'h108));
        #1 reset = 1'b1;
        #1 chk("abort async reset", obs_v[0], IDLE_OBS);
        @(negedge clock);
        chk("abort held reset", obs_v[0], IDLE_OBS);
        reset = 1'b0;

        run_seq(vecs[0], 1'b0, 1'b0);

        // start held through the whole run with bytes changed; restart only from IDLE with new bytes.
        run_seq(vecs[2], 1'b1, 1'b1);
        @(negedge clock);
        chk("restart icw1 new bytes", obs_v[0], write_obs(1'b0, 9'h055));
        start_v[0] = 1'b0;
        #1 reset = 1'b1;
        #1 chk("restart abort", obs_v[0], IDLE_OBS);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("final idle", obs_v[0], IDLE_OBS);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pic_program_sequencer.md
# pic_program_sequencer

Bus-master sequencer that programs the 8259A interrupt controller from a latched configuration. On `start` it issues the full initialization write sequence through the PIC's CPU bus interface (chip select, write strobe, A0, data byte): ICW1, ICW2, optional ICW3, optional ICW4, then OCW1. It sits between a system bring-up or CPU-model block and the 8259A bus interface, so the PIC's ICW/OCW decoder sees properly spaced writes in the legal order.

## Interface
- `WR_PULSE`, default 2: cycles `write_enable_n` is held low per write; values <1 behave as 1.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a programming sequence; sampled only in IDLE.
- `icw1`, `icw2`, `icw3`, `icw4`, `ocw1`  in  8 each  configuration bytes, latched on accepted `start`.
- `ocw3`  in  8  OCW3 byte, latched on accepted `start`; used only with `PIC_SEQ_OCW3_EN`.
- `chip_select_n`  out  1  PIC chip select, active low.
- `write_enable_n`  out  1  PIC write strobe, active low.
- `address`  out  1  PIC A0.
- `data_bus_out`  out  8  byte presented to the PIC data bus.
- `data_bus_out_en`  out  1  high while the sequencer drives the data bus.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse at sequence completion.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, DONE. Step pointer: ICW1, ICW2, ICW3, ICW4, OCW1, then OCW3 (macro only).
- IDLE: `start`=1 latches all bytes, selects step ICW1, goes to SETUP. `start` outside IDLE is ignored.
- SETUP (1 cycle): `chip_select_n`=0, `data_bus_out_en`=1, `address` and `data_bus_out` per step, `write_enable_n`=1.
- STROBE (WR_PULSE cycles): same as SETUP with `write_enable_n`=0. A down-counter of width $clog2(WR_PULSE+1) is loaded on entry.
- HOLD (1 cycle): `write_enable_n`=1; address, data and select held. Then the next step goes to SETUP. After the last step the FSM goes to DONE.
- Step bytes and A0:
  - ICW1: A0=0, data = `icw1` with bit4 forced to 1.
  - ICW2: A0=1, `icw2`.
  - ICW3: A0=1, `icw3`.
  - ICW4: A0=1, `icw4`.
  - OCW1: A0=1, `ocw1`.
  - OCW3: A0=0, `ocw3` with bit7=0, bit4=0 and bit3=1 forced.
- Step skipping uses the latched `icw1`:
  - ICW3 is skipped when bit1 (SNGL)=1.
  - ICW4 is skipped when bit0 (IC4)=0.
  - ICW2 and OCW1 are always issued.
- DONE (1 cycle): `done`=1, all bus outputs at idle values, then return to IDLE. A `start` in DONE is ignored.
- Latched bytes are stable for the whole sequence. Input changes after acceptance have no effect.

## Timing
- Reset values: `chip_select_n`=1, `write_enable_n`=1, `address`=0, `data_bus_out`=8'h00, `data_bus_out_en`=0, `busy`=0, `done`=0. FSM in IDLE.
- Reset mid-sequence returns to IDLE immediately, takes all outputs to reset values, and discards the partial sequence. The next `start` begins again at ICW1.
- `start` sampled at edge k: SETUP of ICW1 is visible after edge k. Each write lasts WR_PULSE+2 cycles.
- With W issued writes, `busy` is high from edge k through the HOLD of the last write. `done` is high for the single cycle after edge k+W·(WR_PULSE+2). IDLE is re-entered one cycle later.
- Address and data are stable at least 1 cycle before the falling edge and 1 cycle after the rising edge of `write_enable_n`. `chip_select_n` stays low continuously across one write only and rises in between writes? No: `chip_select_n` is low from SETUP through HOLD of each write and remains low back-to-back between consecutive writes.
- The minimum spacing between successive `write_enable_n` low pulses is 2 cycles (HOLD + SETUP).

## Configuration
- `PIC_SEQ_OCW3_EN` defined: an OCW3 write (A0=0) follows OCW1, so W grows by 1, and `ocw3` is latched.
- `PIC_SEQ_OCW3_EN` undefined: the sequence ends after OCW1, the `ocw3` port exists but is ignored, and no OCW3 logic is synthesized.

## Test plan
- Single mode without ICW4, macro off, WR_PULSE=2: `icw1`=8'h02 -> writes (A0,data) = (0,8'h12), (1,icw2), (1,ocw1). Each strobe is 2 cycles low and `done` pulses 12 cycles after `start`.
- Cascade mode with ICW4: `icw1`=8'h11 -> 5 writes: (0,8'h11), (1,icw2), (1,icw3), (1,icw4), (1,ocw1). `done` pulses at k+20.
- `PIC_SEQ_OCW3_EN` on, `ocw3`=8'hFF, `icw1`=8'h13 -> last write is (0,8'h6F), and `done` pulses at k+20 (5 writes).
- Reset asserted during the STROBE of ICW2 -> all outputs return to reset values asynchronously. A following `start` restarts at ICW1 with freshly latched bytes.
- `start` held high throughout, plus input bytes changed mid-sequence -> exactly one sequence runs using the original bytes. A new sequence begins only on `start` sampled in IDLE after DONE.
- WR_PULSE=1 and WR_PULSE=0 -> strobes are exactly 1 cycle low and each write lasts 3 cycles.
